// File: rtl/unsigned_mul_8x8_ha_seq_ctrl.sv
// Sequential controller for an 8x8 unsigned multiplier: drives an external HA-array
// row generator and accumulates its four weighted rows, one row per cycle.
module unsigned_mul_8x8_ha_seq_ctrl #(
    parameter logic [3:0] ROW_MASK = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_y,
    output logic [7:0]  gen_x,
    output logic [7:0]  gen_y,
    input  logic [27:0] ha_b,
    input  logic [35:0] ha_t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        out_ovf,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_rc;
    logic [16:0] r_acc;
    logic        r_carry;
    logic [7:0]  r_gen_x;
    logic [7:0]  r_gen_y;
    logic        r_out_valid;
    logic [15:0] r_out_p;
    logic        r_out_ovf;

    logic [8:0]  w_t;
    logic [6:0]  w_b;
    logic [9:0]  w_row;
    logic [17:0] w_wt;
    logic [17:0] w_sum;

    always_comb begin
        w_t = '0;
        w_b = '0;
        case (r_rc)
            2'd0: begin w_t = ha_t[8:0];   w_b = ha_b[6:0];   end
            2'd1: begin w_t = ha_t[17:9];  w_b = ha_b[13:7];  end
            2'd2: begin w_t = ha_t[26:18]; w_b = ha_b[20:14]; end
            default: begin w_t = ha_t[35:27]; w_b = ha_b[27:21]; end
        endcase
        w_row = '0;
        if (ROW_MASK[r_rc])
            w_row = {1'b0, w_t} + {1'b0, w_b, 2'b00};
        w_wt  = {8'b0, w_row} << {r_rc, 1'b0};
        w_sum = {1'b0, r_acc} + w_wt;
    end

    // The product is published one cycle after the last row lands, so DONE
    // spends its first cycle loading the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rc        <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_gen_x     <= '0;
            r_gen_y     <= '0;
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_gen_x <= in_x;
                        r_gen_y <= in_y;
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                        r_rc    <= '0;
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    r_acc   <= w_sum[16:0];
                    r_carry <= r_carry | w_sum[17];
                    r_rc    <= r_rc + 2'd1;
                    if (r_rc == 2'd3)
                        r_state <= DONE;
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_p     <= r_acc[15:0];
                        r_out_ovf   <= r_acc[16] | r_carry;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign gen_x     = r_gen_x;
    assign gen_y     = r_gen_y;
    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_seq_ctrl.sv
// Scoreboard bench: two controllers (full mask and ROW_MASK=1) run in lockstep on
// shared stimulus, fed either by stub rows or a half-adder row generator.
module tb_unsigned_mul_8x8_ha_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_x = '0;
    logic [7:0]  in_y = '0;

    logic        in_ready0, in_ready1, out_valid0, out_valid1, out_ovf0, out_ovf1, busy0, busy1;
    logic [7:0]  gen_x0, gen_y0, gen_x1, gen_y1;
    logic [27:0] ha_b0, ha_b1;
    logic [35:0] ha_t0, ha_t1;
    logic [15:0] out_p0, out_p1;

    logic [8:0]  stub_t [4];
    logic [6:0]  stub_b [4];
    logic        stub_en = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] p0;
        logic        ovf0;
        logic [15:0] p1;
        logic        ovf1;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unsigned_mul_8x8_ha_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_x(in_x), .in_y(in_y), .gen_x(gen_x0), .gen_y(gen_y0),
        .ha_b(ha_b0), .ha_t(ha_t0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_p(out_p0), .out_ovf(out_ovf0), .busy(busy0)
    );

    unsigned_mul_8x8_ha_seq_ctrl #(.ROW_MASK(4'h1)) dut_m1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_x(in_x), .in_y(in_y), .gen_x(gen_x1), .gen_y(gen_y1),
        .ha_b(ha_b1), .ha_t(ha_t1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_p(out_p1), .out_ovf(out_ovf1), .busy(busy1)
    );

    // Row k adds x*y[2k] and x*y[2k+1]<<1 with half adders: sum -> t, carries -> b.
    function automatic logic [63:0] ha_gen(input logic [7:0] x, input logic [7:0] y);
        logic [35:0] t;
        logic [27:0] b;
        logic [8:0]  a, bb, s, c;
        t = '0;
        b = '0;
        for (int k = 0; k < 4; k++) begin
            a  = {1'b0, x & {8{y[2*k]}}};
            bb = {x & {8{y[2*k+1]}}, 1'b0};
            s  = a ^ bb;
            c  = a & bb;
            t[9*k +: 9] = s;
            b[7*k +: 7] = c[7:1];
        end
        return {b, t};
    endfunction

    always_comb begin
        ha_t0 = '0; ha_b0 = '0; ha_t1 = '0; ha_b1 = '0;
        if (stub_en) begin
            for (int k = 0; k < 4; k++) begin
                ha_t0[9*k +: 9] = stub_t[k];
                ha_b0[7*k +: 7] = stub_b[k];
                ha_t1[9*k +: 9] = stub_t[k];
                ha_b1[7*k +: 7] = stub_b[k];
            end
        end else begin
            {ha_b0, ha_t0} = ha_gen(gen_x0, gen_y0);
            {ha_b1, ha_t1} = ha_gen(gen_x1, gen_y1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int stub_ref(input logic [3:0] mask);
        int s = 0;
        for (int k = 0; k < 4; k++)
            if (mask[k]) s += (int'(stub_t[k]) + 4 * int'(stub_b[k])) * (1 << (2 * k));
        return s;
    endfunction

    function automatic int real_ref(input logic [7:0] x, input logic [7:0] y, input logic [3:0] mask);
        logic [7:0] m;
        for (int k = 0; k < 4; k++) m[2*k +: 2] = {2{mask[k]}};
        return int'(x) * int'(y & m);
    endfunction

    task automatic make_exp(input logic [7:0] x, input logic [7:0] y, output exp_t e);
        logic [31:0] s0, s1;
        s0 = stub_en ? stub_ref(4'hF) : real_ref(x, y, 4'hF);
        s1 = stub_en ? stub_ref(4'h1) : real_ref(x, y, 4'h1);
        e.p0 = s0[15:0]; e.ovf0 = (s0 >= 32'd65536);
        e.p1 = s1[15:0]; e.ovf1 = (s1 >= 32'd65536);
        e.acc = 0;
    endtask

    task automatic set_stub(input logic [8:0] t0, input logic [6:0] b0, input logic [8:0] t1, input logic [6:0] b1,
                            input logic [8:0] t2, input logic [6:0] b2, input logic [8:0] t3, input logic [6:0] b3);
        stub_t[0] = t0; stub_b[0] = b0; stub_t[1] = t1; stub_b[1] = b1;
        stub_t[2] = t2; stub_b[2] = b2; stub_t[3] = t3; stub_b[3] = b3;
    endtask

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input bit push);
        exp_t e;
        bit ok = 0;
        make_exp(x, y, e);
        in_x = x; in_y = y; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready0) begin ok = 1; break; end
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        e.acc = cyc + 1;
        if (push && ok) exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        chk("done_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: latency on first valid, stability while stalled, values at handshake.
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_ovf0 = 1'b0;
    logic [15:0] prev_p0 = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("valid_lockstep", 32'(out_valid1), 32'(out_valid0));
            if (out_valid0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    if (!prev_v) chk("latency", 32'(cyc - e.acc), 32'd5);
                    else if (!prev_r) begin
                        chk("hold_p", 32'(out_p0), 32'(prev_p0));
                        chk("hold_ovf", 32'(out_ovf0), 32'(prev_ovf0));
                    end
                    if (out_ready) begin
                        chk("p_full", 32'(out_p0), 32'(e.p0));
                        chk("ovf_full", 32'(out_ovf0), 32'(e.ovf0));
                        chk("p_mask1", 32'(out_p1), 32'(e.p1));
                        chk("ovf_mask1", 32'(out_ovf1), 32'(e.ovf1));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
        prev_v = out_valid0; prev_r = out_ready; prev_p0 = out_p0; prev_ovf0 = out_ovf0;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready0), 32'd1);
        chk({tag, "_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid0), 32'd0);
        chk({tag, "_out_p"}, 32'(out_p0), 32'd0);
        chk({tag, "_out_ovf"}, 32'(out_ovf0), 32'd0);
        chk({tag, "_gen_x"}, 32'(gen_x0), 32'd0);
        chk({tag, "_gen_y"}, 32'(gen_y0), 32'd0);
    endtask

    initial begin
        logic [7:0] rx, ry;
        exp_t e;
        set_stub(9'h001, 7'h0, 9'h001, 7'h0, 9'h001, 7'h0, 9'h001, 7'h0);
        #12;
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Stub rows: unit tops, single-row extremes, all-rows overflow.
        stub_en = 1'b1;
        issue(8'h12, 8'h34, 1); wait_done(0);
        set_stub(9'h1FF, 7'h7F, 9'h0, 7'h0, 9'h0, 7'h0, 9'h0, 7'h0);
        issue(8'h01, 8'h02, 1); wait_done(1);
        set_stub(9'h0, 7'h0, 9'h0, 7'h0, 9'h0, 7'h0, 9'h1FF, 7'h7F);
        issue(8'h03, 8'h04, 1); wait_done(1);
        set_stub(9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F, 9'h1FF, 7'h7F);
        issue(8'h05, 8'h06, 1); wait_done(1);

        // Stall in DONE with new operands pending.
        stub_en = 1'b0;
        out_ready = 1'b0;
        issue(8'hA5, 8'h3C, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid0) break;
        end
        chk("stall_valid", 32'(out_valid0), 32'd1);
        in_x = 8'h5A; in_y = 8'hC3; in_valid = 1'b1;
        make_exp(8'h5A, 8'hC3, e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready0), 32'd0);
            chk("stall_gen_x", 32'(gen_x0), 32'hA5);
            chk("stall_gen_y", 32'(gen_y0), 32'h3C);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        chk("reuse_in_ready", 32'(in_ready0), 32'd1);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("reuse_gen_x", 32'(gen_x0), 32'h5A);
        chk("reuse_gen_y", 32'(gen_y0), 32'hC3);
        wait_done(1);

        // Reset during the second ACC cycle aborts the operation.
        stub_en = 1'b1;
        set_stub(9'h001, 7'h0, 9'h001, 7'h0, 9'h001, 7'h0, 9'h001, 7'h0);
        issue(8'h77, 8'h88, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midacc");
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(8'h11, 8'h22, 1); wait_done(1);

        // Half-adder generator: zero operands, corners, random sweep.
        stub_en = 1'b0;
        issue(8'h00, 8'hB7, 1); wait_done(1);
        issue(8'hC9, 8'h00, 1); wait_done(1);
        issue(8'hFF, 8'hFF, 1); wait_done(1);
        for (int n = 0; n < 40; n++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            issue(rx, ry, 1);
            wait_done(1);
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unsigned_mul_8x8_ha_seq_ctrl.md
UNSIGNED_MUL_8X8_HA_SEQ_CTRL -- requirements
Module: unsigned_mul_8x8_ha_seq_ctrl

Interface
REQ-001: Parameter ROW_MASK, default 4'hF; bit k=1 includes row k in the accumulation, bit k=0 makes row k contribute zero.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: in_valid  input  1  operand pair offered.
REQ-005: in_ready  output  1  controller accepts operands this cycle.
REQ-006: in_x, in_y  input  8 each  unsigned operands.
REQ-007: gen_x, gen_y  output  8 each  registered operands driven to the external combinational HA-array generator.
REQ-008: ha_b  input  28  row k bottom vector at bits [7k+6:7k], k=0..3.
REQ-009: ha_t  input  36  row k top vector at bits [9k+8:9k], k=0..3.
REQ-010: out_valid  output  1  product available.
REQ-011: out_ready  input  1  consumer takes product.
REQ-012: out_p  output  16  accumulated product, modulo 2^16.
REQ-013: out_ovf  output  1  unreduced sum was >= 2^16.
REQ-014: busy  output  1  high in any state other than IDLE.

Function
REQ-015: The FSM SHALL have states IDLE, ACC and DONE, plus a 2-bit row counter rc.
REQ-016: In IDLE, in_ready SHALL be 1; in ACC and DONE it SHALL be 0, so operations never overlap.
REQ-017: On in_valid & in_ready, the block SHALL latch in_x/in_y into gen_x/gen_y, clear the 17-bit accumulator, set rc=0 and enter ACC.
REQ-018: gen_x/gen_y SHALL hold their values from accept until the next accept.
REQ-019: In ACC, each cycle the block SHALL add row rc, weighted (t + 4*b) << (2*rc), to the accumulator (t = 9-bit top, b = 7-bit bottom), then increment rc.
REQ-020: Row rc SHALL be sampled from ha_b/ha_t in the same cycle it is added, i.e. after the generator has seen stable gen_x/gen_y for at least one cycle.
REQ-021: The ACC state SHALL last exactly 4 cycles (rc = 0..3); after rc=3 the FSM SHALL enter DONE.
REQ-022: Latency: accept at edge N gives out_valid=1 after edge N+5.
REQ-023: In DONE, out_valid SHALL be 1, out_p SHALL equal accumulator[15:0] and out_ovf SHALL equal accumulator[16] OR any intermediate carry beyond bit 16.
REQ-024: out_p and out_ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025: On out_valid & out_ready, the FSM SHALL return to IDLE; in_ready SHALL rise the following cycle, so there is no same-cycle reuse.
REQ-026: in_valid asserted while not in IDLE SHALL be ignored, and the upstream SHALL hold it.
REQ-027: Rows with ROW_MASK[k]=0 SHALL still consume their ACC cycle, so latency stays fixed.
REQ-028: out_ready while out_valid=0 SHALL have no effect.
REQ-029: ha_b/ha_t SHALL be ignored outside ACC.

Reset
REQ-030: On rst_n=0 the block SHALL, asynchronously: set state=IDLE, rc=0, accumulator=0, gen_x=gen_y=0, out_valid=0, out_p=0, out_ovf=0, busy=0 and in_ready=1.
REQ-031: A reset asserted mid-ACC or in DONE SHALL abort the operation with no output, and the pending product SHALL be lost.
REQ-032: After reset release, the first rising edge SHALL be able to accept an operand.

Verification
REQ-033: Stub generator with every row t=9'h001, b=0 and ROW_MASK=4'hF -> out_p=16'h0055, out_ovf=0, out_valid exactly 5 edges after accept.
REQ-034: Row0 t=9'h1FF, b=7'h7F, other rows 0 -> out_p=16'h03FB; same values on row3 only -> out_p=16'hFEC0, out_ovf=0.
REQ-035: All rows t=9'h1FF, b=7'h7F -> out_p=16'h5257, out_ovf=1; with ROW_MASK=4'h1 -> out_p=16'h03FB, out_ovf=0, latency unchanged.
REQ-036: Hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands -> out_p stable, in_ready=0, gen_x/gen_y unchanged; after the out_ready pulse, the next operand is accepted one cycle later.
REQ-037: Assert rst_n=0 at the 2nd ACC cycle -> all outputs at reset values immediately; after release, a fresh operation with stub rows all t=9'h001, b=0 gives out_p=16'h0055.
REQ-038: Real generator connected, x=8'h00 or y=8'h00 -> out_p=0; random sweep compared against a bit-exact software model of the row weighting.
